// File: rtl/router_1x3.sv
// router_1x3: steers byte-serial packets into one of three 32-deep FIFOs by the
// header address field, storing header/payload/parity and checking XOR parity.

module router_1x3_fifo (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       not_empty,
    output logic       full
);
    logic [7:0] mem_q [32];
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] wr_addr;
    logic [5:0] cnt_q, cnt_d;
    logic [4:0] tmo_q, tmo_d;
    logic       push, pop, flush;

    assign not_empty = (cnt_q != 6'd0);
    assign full      = (cnt_q == 6'd32);
    assign rd_data   = not_empty ? mem_q[rd_ptr_q] : 8'h00;

    always_comb begin
        pop      = rd_en && not_empty;
        // 30th consecutive unread cycle with data pending drops the whole FIFO
        flush    = not_empty && !rd_en && (tmo_q == 5'd29);
        push     = wr_en && !full;
        wr_addr  = flush ? 5'd0 : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = 5'd0;
            wr_ptr_d = push ? 5'd1 : 5'd0;
            cnt_d    = push ? 6'd1 : 6'd0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + 5'd1;
            if (push) wr_ptr_d = wr_ptr_q + 5'd1;
            cnt_d = cnt_q + {5'd0, push} - {5'd0, pop};
        end
        tmo_d = (not_empty && !rd_en && !flush) ? tmo_q + 5'd1 : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rd_ptr_q <= 5'd0;
            wr_ptr_q <= 5'd0;
            cnt_q    <= 6'd0;
            tmo_q    <= 5'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_addr] <= wr_data;
    end
endmodule

module router_1x3 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       read_enable0,
    input  logic       read_enable1,
    input  logic       read_enable2,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       busy,
    output logic       error
);
    typedef enum logic [2:0] {
        IDLE, WAIT_EMPTY, LOAD_HEADER, LOAD_DATA, CHECK_PARITY
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] rx_par_q, rx_par_d;
    logic [1:0] addr_q, addr_d;
    logic       error_q, error_d;
    logic       skip_q, skip_d;
    logic       do_wr;
    logic [7:0] wr_byte;
    logic [2:0] fifo_we, fifo_re, fifo_vld, fifo_full;
    logic [7:0] fifo_rdata [3];
    logic [3:0] vld4, full4;

    assign fifo_re = {read_enable2, read_enable1, read_enable0};
    assign vld4    = {1'b0, fifo_vld};
    assign full4   = {1'b0, fifo_full};

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        assign fifo_we[i] = do_wr && (addr_q == 2'(i));
        router_1x3_fifo u_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .wr_en     (fifo_we[i]),
            .wr_data   (wr_byte),
            .rd_en     (fifo_re[i]),
            .rd_data   (fifo_rdata[i]),
            .not_empty (fifo_vld[i]),
            .full      (fifo_full[i])
        );
    end

    assign data_out0  = fifo_rdata[0];
    assign data_out1  = fifo_rdata[1];
    assign data_out2  = fifo_rdata[2];
    assign valid_out0 = fifo_vld[0];
    assign valid_out1 = fifo_vld[1];
    assign valid_out2 = fifo_vld[2];
    assign error      = error_q;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        rx_par_d = rx_par_q;
        error_d  = error_q;
        skip_d   = skip_q;
        do_wr    = 1'b0;
        wr_byte  = data_in;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // skip_q swallows the rest of an addr-3 packet so its payload
                // bytes are never mistaken for a header
                if (!pkt_valid) begin
                    skip_d = 1'b0;
                end else if (!skip_q) begin
                    if (data_in[1:0] == 2'd3) begin
                        skip_d = 1'b1;
                    end else begin
                        hdr_d   = data_in;
                        addr_d  = data_in[1:0];
                        state_d = vld4[data_in[1:0]] ? WAIT_EMPTY : LOAD_HEADER;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (!vld4[addr_q]) state_d = LOAD_HEADER;
            end
            LOAD_HEADER: begin
                busy    = 1'b1;
                do_wr   = 1'b1;
                wr_byte = hdr_q;
                acc_d   = hdr_q;
                error_d = 1'b0;
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = full4[addr_q];
                if (!full4[addr_q]) begin
                    do_wr = 1'b1;
                    if (pkt_valid) begin
                        acc_d = acc_q ^ data_in;
                    end else begin
                        rx_par_d = data_in;
                        state_d  = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                busy    = 1'b1;
                error_d = (acc_q != rx_par_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= IDLE;
            hdr_q    <= 8'h00;
            addr_q   <= 2'd0;
            acc_q    <= 8'h00;
            rx_par_q <= 8'h00;
            error_q  <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            rx_par_q <= rx_par_d;
            error_q  <= error_d;
            skip_q   <= skip_d;
        end
    end
endmodule

// File: tb/tb_router_1x3.sv
// Bench for router_1x3: directed packet table, multi-cycle corner sequences and
// random traffic, all checked every cycle against a queue-based packet model.

module tb_router_1x3;
    logic       clk = 1'b0;
    logic       resetn, pkt_valid;
    logic [7:0] data_in;
    logic [2:0] re;
    logic [7:0] data_out0, data_out1, data_out2;
    logic       valid_out0, valid_out1, valid_out2, busy, error;
    logic [2:0] vo;
    logic [7:0] dout [3];

    always #5 clk = ~clk;

    router_1x3 dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .read_enable0(re[0]), .read_enable1(re[1]), .read_enable2(re[2]),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2),
        .busy(busy), .error(error)
    );

    assign vo      = {valid_out2, valid_out1, valid_out0};
    assign dout[0] = data_out0;
    assign dout[1] = data_out1;
    assign dout[2] = data_out2;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: one byte queue per output port plus packet-phase tracking
    logic [7:0] mq [3][$];
    logic [7:0] plog [3][$];
    int         mtmo [3] = '{0, 0, 0};
    int         mph = 0;   // 0 idle, 1 wait empty, 2 header, 3 data, 4 check
    logic [1:0] mdst = 2'd0;
    logic [7:0] mhdr = 8'h00, macc = 8'h00, mrx = 8'h00;
    logic       merr = 1'b0, mskip = 1'b0;
    bit         mon_en = 1'b0, saw_stall = 1'b0;

    function automatic logic m_busy();
        case (mph)
            1, 2, 4: return 1'b1;
            3:       return mq[mdst].size() == 32;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_step();
        int         sz [3];
        int         wp;
        logic [7:0] wb;
        bit         fl;
        if (resetn) begin
            for (int p = 0; p < 3; p++) begin
                mq[p].delete();
                mtmo[p] = 0;
            end
            mph = 0; merr = 1'b0; mskip = 1'b0;
            return;
        end
        for (int p = 0; p < 3; p++) sz[p] = mq[p].size();
        wp = -1;
        wb = 8'h00;
        case (mph)
            0: begin
                if (!pkt_valid) mskip = 1'b0;
                else if (!mskip) begin
                    if (data_in[1:0] == 2'd3) mskip = 1'b1;
                    else begin
                        mdst = data_in[1:0];
                        mhdr = data_in;
                        mph  = (sz[mdst] > 0) ? 1 : 2;
                    end
                end
            end
            1: if (sz[mdst] == 0) mph = 2;
            2: begin
                wp = int'(mdst); wb = mhdr; macc = mhdr; merr = 1'b0; mph = 3;
            end
            3: begin
                if (sz[mdst] < 32) begin
                    wp = int'(mdst);
                    wb = data_in;
                    if (pkt_valid) macc = macc ^ data_in;
                    else begin
                        mrx = data_in;
                        mph = 4;
                    end
                end
            end
            default: begin
                merr = (macc != mrx);
                mph  = 0;
            end
        endcase
        for (int p = 0; p < 3; p++) begin
            fl = (sz[p] > 0) && !re[p] && (mtmo[p] == 29);
            if (re[p] && sz[p] > 0) void'(mq[p].pop_front());
            if (fl) mq[p].delete();
            if (wp == p) mq[p].push_back(wb);
            mtmo[p] = ((sz[p] > 0) && !re[p] && !fl) ? mtmo[p] + 1 : 0;
        end
    endfunction

    // Outputs depend only on registers and inputs change only at posedge+1,
    // so the falling edge is a stable point to compare and then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, m_busy());
            chk("error", error, merr);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("valid_out%0d", p), vo[p], mq[p].size() != 0);
                chk($sformatf("data_out%0d", p), dout[p],
                    (mq[p].size() != 0) ? mq[p][0] : 8'h00);
                if (re[p] && vo[p]) plog[p].push_back(dout[p]);
            end
            if (busy && mph == 3) saw_stall = 1'b1;
            model_step();
        end
    end

    // Reader: 0 never, 1 always, 2 every 8th cycle, 3 random
    int rd_mode [3] = '{0, 0, 0};
    int cyc = 0;
    initial begin
        re = 3'b000;
        forever begin
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 3; p++) begin
                case (rd_mode[p])
                    0:       re[p] = 1'b0;
                    1:       re[p] = 1'b1;
                    2:       re[p] = (cyc % 8 == 0);
                    default: re[p] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    logic [7:0] sent_q [$];
    bit         busy_seen;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a byte and hold it until a cycle with busy=0 consumes it.
    task automatic put(input logic [7:0] b, input logic v);
        int n = 0;
        data_in = b;
        pkt_valid = v;
        while (busy && n < 400) begin
            busy_seen = 1'b1;
            step();
            n++;
        end
        chk("put_busy_bound", busy, 1'b0);
        step();
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input bit bad, input int err_before);
        logic [7:0] par, b;
        int len;
        len = int'(hdr[7:2]);
        sent_q.delete();
        busy_seen = 1'b0;
        put(hdr, 1'b1);
        sent_q.push_back(hdr);
        par = hdr;
        if (err_before >= 0) chk("err_hold_at_hdr", error, err_before);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            put(b, 1'b1);
            sent_q.push_back(b);
            par = par ^ b;
        end
        if (bad) par = par ^ 8'h5A;
        put(par, 1'b0);
        sent_q.push_back(par);
        data_in = 8'h00;
        pkt_valid = 1'b0;
    endtask

    task automatic drain(input int p);
        int n = 0;
        rd_mode[p] = 1;
        step();
        while (vo[p] && n < 100) begin
            step();
            n++;
        end
        chk("drain_done", vo[p], 1'b0);
        rd_mode[p] = 0;
        step();
    endtask

    task automatic check_log(input int p, input string name);
        int bad_at = -1;
        chk({name, "_count"}, plog[p].size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < plog[p].size(); i++)
            if (bad_at < 0 && plog[p][i] !== sent_q[i]) bad_at = i;
        chk({name, "_order"}, bad_at, -1);
    endtask

    task automatic clear_logs();
        for (int p = 0; p < 3; p++) plog[p].delete();
    endtask

    typedef struct {
        logic [7:0] hdr;
        bit         bad;
        int         port;     // -1: invalid address, nothing stored
        bit         exp_err;
    } vec_t;

    vec_t       vecs [7];
    int         prev_err;
    logic [7:0] b, hdr;

    initial begin
        vecs[0] = '{8'h24, 1'b0,  0, 1'b0};  // len 9, port 0, good
        vecs[1] = '{8'h39, 1'b1,  1, 1'b1};  // len 14, port 1, bad parity
        vecs[2] = '{8'h0F, 1'b0, -1, 1'b1};  // addr 3: ignored, error holds
        vecs[3] = '{8'h42, 1'b0,  2, 1'b0};  // len 16, port 2, 18 bytes fit
        vecs[4] = '{8'h05, 1'b1,  1, 1'b1};  // len 1, bad
        vecs[5] = '{8'h00, 1'b0,  0, 1'b0};  // len 0: header then parity
        vecs[6] = '{8'h1B, 1'b1, -1, 1'b0};  // addr 3 with clean error

        resetn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        step();
        mon_en = 1'b1;
        step();
        resetn = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_valid", vo, 3'b000);
        chk("rst_data", {data_out2, data_out1, data_out0}, 24'h0);

        prev_err = 0;
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            send_pkt(vecs[i].hdr, vecs[i].bad, prev_err);
            chk("err_at_parity", error, (vecs[i].port < 0) ? prev_err : 0);
            step();
            chk("err_final", error, vecs[i].exp_err);
            chk("valid_mask", vo, (vecs[i].port < 0) ? 0 : (1 << vecs[i].port));
            if (vecs[i].port < 0) chk("inv_busy", busy_seen, 1'b0);
            else begin
                drain(vecs[i].port);
                check_log(vecs[i].port, "vec");
            end
            prev_err = vecs[i].exp_err;
        end

        // Mid-packet reset with error set and port 1 holding data
        send_pkt(8'h09, 1'b1, -1);
        step();
        chk("pre_rst_err", error, 1'b1);
        put(8'h24, 1'b1); put(8'hA5, 1'b1); put(8'h3C, 1'b1);
        resetn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        step();
        resetn = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        chk("mid_rst_valid", vo, 3'b000);
        chk("mid_rst_data", {data_out2, data_out1, data_out0}, 24'h0);
        clear_logs();
        send_pkt(8'h11, 1'b0, 0);
        step();
        chk("post_rst_err", error, 1'b0);
        chk("post_rst_mask", vo, 3'b010);
        drain(1);
        check_log(1, "post_rst");

        // Timeout: header written 3 edges before the parity byte; flush on the 30th
        send_pkt(8'h08, 1'b0, -1);
        for (int k = 0; k < 26; k++) step();
        chk("tmo_before", vo[0], 1'b1);
        step();
        chk("tmo_flush", vo[0], 1'b0);

        // Back-to-back to a non-empty port parks in WAIT_EMPTY
        clear_logs();
        send_pkt(8'h04, 1'b0, -1);
        put(8'h04, 1'b1);
        sent_q.push_back(8'h04);
        for (int k = 0; k < 5; k++) step();
        chk("wait_busy", busy, 1'b1);
        chk("wait_vld", vo[0], 1'b1);
        rd_mode[0] = 1;
        b = 8'($urandom);
        put(b, 1'b1);
        put(8'h04 ^ b, 1'b0);
        sent_q.push_back(b);
        sent_q.push_back(8'h04 ^ b);
        data_in = 8'h00; pkt_valid = 1'b0;
        drain(0);
        check_log(0, "b2b");
        chk("b2b_err", error, 1'b0);

        // Overflow: len-40 packet with a slow reader stalls on full FIFO 2
        clear_logs();
        saw_stall = 1'b0;
        rd_mode[2] = 2;
        send_pkt(8'hA2, 1'b0, -1);
        step();
        chk("ovf_stall_seen", saw_stall, 1'b1);
        chk("ovf_err", error, 1'b0);
        drain(2);
        check_log(2, "ovf");

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 3; p++) rd_mode[p] = $urandom_range(0, 3);
            hdr = {6'($urandom_range(0, 24)), 2'($urandom_range(0, 3))};
            send_pkt(hdr, 1'($urandom_range(0, 1)), -1);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
        end
        for (int p = 0; p < 3; p++) rd_mode[p] = 1;
        for (int k = 0; k < 40; k++) step();
        chk("final_empty", vo, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/router_1x3.md
# router_1x3

Single-input, three-output packet router. Byte-serial packets arrive on `data_in`. Each packet is steered by the address field in its header into one of three 32-entry output FIFOs, and its even-XOR parity is checked. Downstream readers drain each FIFO independently with their own read enables. The block sits between a packet source that honours `busy` and three consumers.

## Interface
- No parameters. FIFO depth is fixed at 32 × 8 bits per port.
- `clk` in 1: the single clock; everything updates on the rising edge.
- `resetn` in 1: synchronous, active-high reset (asserted = 1).
- `pkt_valid` in 1: high for the header and payload bytes, low for the parity byte.
- `data_in` in 8: packet byte stream.
- `read_enable0/1/2` in 1 each: pop one byte from FIFO n.
- `data_out0/1/2` out 8 each: head byte of FIFO n; 0 when the FIFO is empty.
- `valid_out0/1/2` out 1 each: FIFO n is not empty.
- `busy` out 1: source must hold `data_in` and `pkt_valid` unchanged while this is 1.
- `error` out 1: parity mismatch flag for the last completed packet.

## Operation
- **Packet format.**
  - Header byte = {len[7:2], addr[1:0]}.
  - Then len payload bytes with `pkt_valid`=1.
  - Then one parity byte with `pkt_valid`=0.
  - Parity = XOR of the header and all payload bytes.
- **Destination.** addr 0/1/2 selects FIFO 0/1/2. addr 3 is invalid: the FSM stays in IDLE and the bytes are ignored until `pkt_valid` falls.
- **Stored bytes.** The header, payload and parity byte are all written into the destination FIFO.
- **FSM states.**
  - IDLE (busy=0): on `pkt_valid`=1 with a valid addr, latch the header and addr. Go to LOAD_HEADER if the destination FIFO is empty, else WAIT_EMPTY.
  - WAIT_EMPTY (busy=1): stay until the destination FIFO is empty, then go to LOAD_HEADER.
  - LOAD_HEADER (busy=1): write the latched header, set the parity accumulator to the header, clear `error`, go to LOAD_DATA.
  - LOAD_DATA: busy = destination FIFO full.
    - If not full and `pkt_valid`=1: write `data_in` and XOR it into the accumulator.
    - If not full and `pkt_valid`=0: write `data_in` as the parity byte, latch it, go to CHECK_PARITY.
    - If full: no write.
  - CHECK_PARITY (busy=1): `error` <= (accumulator != received parity byte). Go to IDLE.
- **Payload counting.** Payload length is not counted; the end of the payload is marked only by `pkt_valid` falling.
- **FIFOs.**
  - Circular buffers with 5-bit pointers plus a 6-bit occupancy count. Full = 32, empty = 0.
  - Read pops when `read_enable`n=1 and `valid_out`n=1. Reading an empty FIFO has no effect.
  - A simultaneous read and write in the same cycle keeps the count unchanged. A write to a full FIFO is suppressed.
  - `data_out`n shows the head byte combinationally (first-word fall-through).
- **Read timeout.**
  - Each port counts consecutive cycles with `valid_out`n=1 and `read_enable`n=0.
  - When the count reaches 30, that FIFO is flushed: pointers and count are cleared, and the counter clears.
  - A read, or an empty FIFO, clears the counter.
  - If the flushed FIFO is the current write destination, writing continues normally afterwards.
- **Error flag.** `error` holds its value until the next LOAD_HEADER or reset.

## Timing
- Reset (synchronous, any state, mid-packet included):
  - FSM returns to IDLE.
  - All FIFOs are emptied and timeout counters cleared.
  - Outputs: `busy`=0, `error`=0, `valid_out`n=0, `data_out`n=0.
- Header handshake, counted from the cycle the header is sampled in IDLE:
  - `busy` goes to 1 on the next cycle.
  - The source holds the header while `busy`=1.
  - The first payload byte is accepted the cycle after LOAD_HEADER.
- Payload: one byte per clock while `busy`=0.
- Write to output visibility: `valid_out`n and `data_out`n reflect a written byte the cycle after the write edge.
- Error timing: `error` updates one cycle after the parity byte is written. The FSM is back in IDLE, ready for a new header, one cycle after that.
- Read: after a pop, `data_out`n shows the next byte after that edge.

## Test plan
- **Reset.** Assert `resetn`=1 for one cycle mid-packet, then release → all outputs are 0 and the next header is accepted normally.
- **Port 0, good parity.** Header 0x24 (len 9, addr 0), 9 random bytes, correct parity → `valid_out0`=1. Reading returns all 11 bytes in order, then `valid_out0`=0 and `error`=0.
- **Port 1, bad parity.** Header 0x39 (len 14, addr 1) with a corrupted parity byte → `error`=1 one cycle after the parity write. `error` stays 1 until the next header reaches LOAD_HEADER.
- **Port 2, overflow stall.** Header 0x42 (len 16, addr 2), `read_enable2` held low → the 18 bytes fit. Then send a len-40 packet to port 2 with no reads → `busy`=1 once FIFO 2 holds 32 bytes. Asserting `read_enable2` resumes acceptance, and no byte is lost or duplicated.
- **Timeout and back-to-back.**
  - Leave FIFO 0 unread for 30 cycles → FIFO 0 flushes and `valid_out0`=0.
  - Send a second addr-0 packet while FIFO 0 is non-empty → FSM waits in WAIT_EMPTY with `busy`=1 until FIFO 0 drains.
- **Invalid address.** Header with addr=3 → no FIFO is written and `busy` stays 0.
